// File: rtl/bitslice_psum_reconstructor.sv
// Collects the bit-slice partial-sum beat stream and shift-accumulates it into a full-precision
// dot product; binary mode maps a popcount to 2*pop-N. Saturation is enabled by PSUM_RECON_SAT_EN.
module bitslice_psum_reconstructor #(
  parameter int PSUM_W = 16,
  parameter int OUT_W  = 32,
  parameter int ACC_W  = PSUM_W + 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cfg_bin,
  input  logic [1:0]        cfg_iprec,
  input  logic [1:0]        cfg_wprec,
  input  logic [15:0]       cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PSUM_W-1:0] in_psum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t                   state, state_nx;
  logic signed [ACC_W-1:0]  acc, acc_nx;
  logic signed [ACC_W-1:0]  psum_ext, len_ext;
  logic [1:0]               wi, ii, wi_max, ii_max;
  logic [3:0]               shamt;
  logic                     bin_q;
  logic [15:0]              len_q;
  logic                     beat, last_beat;
  logic [OUT_W-1:0]         res_fmt;

  // Highest slice index for a precision code; code 3 behaves like 8b.
  function automatic logic [1:0] slice_max(input logic [1:0] code);
    case (code)
      2'd0:    slice_max = 2'd0;
      2'd1:    slice_max = 2'd1;
      default: slice_max = 2'd3;
    endcase
  endfunction

  assign in_ready  = (state == ACC);
  assign out_valid = (state == OUT);
  assign beat      = (state == ACC) && in_valid;
  assign last_beat = beat && (bin_q || (wi == wi_max && ii == ii_max));

  assign psum_ext = {{(ACC_W-PSUM_W){in_psum[PSUM_W-1]}}, in_psum};
  assign len_ext  = {{(ACC_W-16){1'b0}}, len_q};
  assign shamt    = {({1'b0, ii} + {1'b0, wi}), 1'b0};

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)     state_nx = ACC;
      ACC:     if (last_beat) state_nx = OUT;
      OUT:     if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_comb begin
    acc_nx = acc;
    if (beat) begin
      if (bin_q) acc_nx = (psum_ext <<< 1) - len_ext;
      else       acc_nx = acc + (psum_ext <<< shamt);
    end
  end

  // Result formatting applied to the value that completes the accumulation.
  generate
    if (ACC_W > OUT_W) begin : g_narrow
      logic ovf;
      assign ovf = !((&acc_nx[ACC_W-1:OUT_W-1]) || !(|acc_nx[ACC_W-1:OUT_W-1]));
`ifdef PSUM_RECON_SAT_EN
      always_comb begin
        res_fmt = acc_nx[OUT_W-1:0];
        if (ovf) res_fmt = acc_nx[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                           : {1'b0, {(OUT_W-1){1'b1}}};
      end
`else
      logic unused_ovf;
      assign unused_ovf = ovf;
      assign res_fmt    = acc_nx[OUT_W-1:0];
`endif
    end else begin : g_wide
      assign res_fmt = OUT_W'(acc_nx);
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      wi       <= '0;
      ii       <= '0;
      wi_max   <= '0;
      ii_max   <= '0;
      bin_q    <= 1'b0;
      len_q    <= '0;
      out_data <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            bin_q  <= cfg_bin;
            len_q  <= cfg_len;
            wi_max <= slice_max(cfg_wprec);
            ii_max <= slice_max(cfg_iprec);
            acc    <= '0;
            wi     <= '0;
            ii     <= '0;
          end
        end
        ACC: begin
          if (beat) begin
            acc <= acc_nx;
            if (last_beat) begin
              wi       <= '0;
              ii       <= '0;
              out_data <= res_fmt;
            end else if (wi == wi_max) begin
              wi <= '0;
              ii <= ii + 2'd1;
            end else begin
              wi <= wi + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitslice_psum_reconstructor.sv
// Self-checking bench: directed scenarios plus randomized operations against an arithmetic model,
// run on a default-width instance and an OUT_W=16 instance sharing the same stimulus.
module tb_bitslice_psum_reconstructor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cfg_bin = 1'b0;
  logic [1:0]  cfg_iprec = '0;
  logic [1:0]  cfg_wprec = '0;
  logic [15:0] cfg_len = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_psum = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, in_ready16, out_valid16;
  logic [31:0] out_data;
  logic [15:0] out_data16;

  int n_checks = 0;
  int n_fail   = 0;
  int beats[16];

  always #5 clk = ~clk;

  bitslice_psum_reconstructor dut (
    .clk(clk), .rst(rst), .start(start), .cfg_bin(cfg_bin), .cfg_iprec(cfg_iprec),
    .cfg_wprec(cfg_wprec), .cfg_len(cfg_len), .in_valid(in_valid), .in_ready(in_ready),
    .in_psum(in_psum), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  bitslice_psum_reconstructor #(.OUT_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .cfg_bin(cfg_bin), .cfg_iprec(cfg_iprec),
    .cfg_wprec(cfg_wprec), .cfg_len(cfg_len), .in_valid(in_valid), .in_ready(in_ready16),
    .in_psum(in_psum), .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int nslices(input logic [1:0] code);
    return (code == 2'd0) ? 1 : (code == 2'd1) ? 2 : 4;
  endfunction

  // Dot product from slice weights: beat k = ii*nW + wi carries weight 4^(ii+wi).
  function automatic longint model(input logic bin, input logic [1:0] ip, input logic [1:0] wp,
                                   input logic [15:0] len);
    longint sum = 0;
    int nw = nslices(wp);
    if (bin) return 2 * longint'(beats[0]) - longint'(len);
    for (int i = 0; i < nslices(ip); i++)
      for (int w = 0; w < nw; w++)
        sum += longint'(beats[i*nw + w]) * (longint'(1) << (2 * (i + w)));
    return sum;
  endfunction

  function automatic longint fmt(input longint v, input int w);
    longint hi = (longint'(1) << (w - 1)) - 1;
    longint lo = -(longint'(1) << (w - 1));
    longint m  = longint'(1) << w;
    longint t;
`ifdef PSUM_RECON_SAT_EN
    t = (v > hi) ? hi : (v < lo) ? lo : v;
    if (m == 0) t = 0;
`else
    t = v % m;
    if (t < 0) t += m;
    if (t > hi) t -= m;
    if (lo > 0) t = 0;
`endif
    return t;
  endfunction

  // One full operation: start, beats (optionally with gaps), result check, backpressure, transfer.
  task automatic run_op(input string tag, input logic bin, input logic [1:0] ip, input logic [1:0] wp,
                        input logic [15:0] len, input longint exp32, input longint exp16,
                        input bit gaps, input int hold);
    int nb = bin ? 1 : nslices(ip) * nslices(wp);
    cfg_bin = bin; cfg_iprec = ip; cfg_wprec = wp; cfg_len = len;
    start = 1'b1; in_valid = 1'b1; in_psum = 16'h7fff;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_bin = $urandom; cfg_iprec = $urandom; cfg_wprec = $urandom; cfg_len = $urandom;
    for (int k = 0; k < nb; k++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0; start = 1'b1; in_psum = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (k == 0) check({tag, " in_ready"}, {63'd0, in_ready}, 1);
      in_valid = 1'b1; in_psum = beats[k][15:0];
      @(posedge clk); #1;
      if (k != nb - 1) check({tag, " early_valid"}, {63'd0, out_valid}, 0);
    end
    in_valid = 1'b0;
    check({tag, " out_valid"}, {63'd0, out_valid}, 1);
    check({tag, " out_data"}, $signed(out_data), exp32);
    check({tag, " out_data16"}, $signed(out_data16), exp16);
    for (int h = 0; h < hold; h++) begin
      start = h[0]; in_valid = 1'b1; in_psum = $urandom; cfg_bin = $urandom;
      @(posedge clk); #1;
      check({tag, " hold_valid"}, {63'd0, out_valid}, 1);
      check({tag, " hold_ready"}, {63'd0, in_ready}, 0);
      check({tag, " hold_data"}, $signed(out_data), exp32);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " drop_valid"}, {63'd0, out_valid}, 0);
    check({tag, " kept_data"}, $signed(out_data), exp32);
  endtask

  initial begin
    longint ref_v;
    logic b;
    logic [1:0] ip, wp;
    logic [15:0] len;

    repeat (2) @(posedge clk);
    check("reset in_ready", {63'd0, in_ready}, 0);
    check("reset out_valid", {63'd0, out_valid}, 0);
    check("reset out_data", $signed(out_data), 0);
    check("reset out_data16", $signed(out_data16), 0);
    #1 rst = 1'b0;
    in_valid = 1'b1; in_psum = 16'h1234;
    repeat (2) @(posedge clk);
    #1 check("idle in_ready", {63'd0, in_ready}, 0);
    in_valid = 1'b0;

    beats[0] = -3;
    run_op("2x2", 1'b0, 2'd0, 2'd0, 16'd0, -3, -3, 1'b0, 0);

    beats[0] = 1; beats[1] = 2; beats[2] = 3; beats[3] = 4;
    run_op("4x4", 1'b0, 2'd1, 2'd1, 16'd0, 85, 85, 1'b1, 0);

    beats[0] = 40;
    run_op("bin40", 1'b1, 2'd2, 2'd2, 16'd64, 16, 16, 1'b0, 0);
    beats[0] = 0;
    run_op("bin0", 1'b1, 2'd0, 2'd1, 16'd64, -64, -64, 1'b0, 0);
    beats[0] = 5;
    run_op("binlen0", 1'b1, 2'd0, 2'd0, 16'd0, 10, 10, 1'b0, 0);

    beats[0] = 1; beats[1] = 2; beats[2] = 3; beats[3] = 4;
    run_op("backpressure", 1'b0, 2'd1, 2'd1, 16'd0, 85, 85, 1'b0, 5);

    // Reset during a 4b x 4b accumulation after two beats.
    cfg_bin = 1'b0; cfg_iprec = 2'd1; cfg_wprec = 2'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1;
    in_psum = 16'd1; @(posedge clk); #1;
    in_psum = 16'd2; @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1; #1;
    check("midrst in_ready", {63'd0, in_ready}, 0);
    check("midrst out_valid", {63'd0, out_valid}, 0);
    check("midrst out_data", $signed(out_data), 0);
    @(posedge clk); #1 rst = 1'b0;
    run_op("after_rst", 1'b0, 2'd1, 2'd1, 16'd0, 85, 85, 1'b0, 0);

    for (int k = 0; k < 16; k++) beats[k] = 32767;
`ifdef PSUM_RECON_SAT_EN
    run_op("overflow", 1'b0, 2'd2, 2'd2, 16'd0, 236741575, 32767, 1'b0, 0);
`else
    run_op("overflow", 1'b0, 2'd2, 2'd2, 16'd0, 236741575, 25543, 1'b0, 0);
`endif

    for (int r = 0; r < 30; r++) begin
      b   = ($urandom_range(0, 3) == 0);
      ip  = $urandom;
      wp  = $urandom;
      len = $urandom;
      for (int k = 0; k < 16; k++) beats[k] = int'($signed(16'($urandom)));
      ref_v = model(b, ip, wp, len);
      run_op($sformatf("rand%0d", r), b, ip, wp, len, fmt(ref_v, 32), fmt(ref_v, 16),
             1'b1, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
